// File: rtl/regfile_scan_checker.sv
// End-of-run register-file checker: counts N processor cycles, then steals read
// port A to sweep every register and compare it against an expected-value ROM.
module regfile_scan_checker #(
  parameter int NUM_REGS = 32,
  parameter int CYC_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CYC_W-1:0] num_cycles,
  input  logic [4:0]       cpu_rs1,
  input  logic [31:0]      data_readRegA,
  input  logic [31:0]      exp_q,
  output logic [4:0]       ctrl_readRegA,
  output logic [4:0]       exp_addr,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [5:0]       error_count,
  output logic             mismatch_valid,
  output logic [4:0]       mismatch_reg,
  output logic [31:0]      mismatch_exp,
  output logic [31:0]      mismatch_act
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_SCAN, S_DRAIN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CYC_W-1:0] n_q, n_d;
  logic [CYC_W-1:0] cnt_q, cnt_d;
  logic [4:0]       scan_idx_q, scan_idx_d;
  logic             cmp_vld_q, cmp_vld_d;
  logic [5:0]       err_q, err_d;
  logic [4:0]       mm_reg_q, mm_reg_d;
  logic [31:0]      mm_exp_q, mm_exp_d;
  logic [31:0]      mm_act_q, mm_act_d;
  logic [31:0]      act_q, act_d;
  logic [4:0]       cmp_idx_q, cmp_idx_d;
  logic             start_ok;
  logic             mismatch;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      cnt_q      <= '0;
      scan_idx_q <= '0;
      cmp_vld_q  <= 1'b0;
      err_q      <= '0;
      mm_reg_q   <= '0;
      mm_exp_q   <= '0;
      mm_act_q   <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      scan_idx_q <= scan_idx_d;
      cmp_vld_q  <= cmp_vld_d;
      err_q      <= err_d;
      mm_reg_q   <= mm_reg_d;
      mm_exp_q   <= mm_exp_d;
      mm_act_q   <= mm_act_d;
    end
  end

  // Compare-stage operands; only consumed when cmp_vld_q is set, so no reset.
  always_ff @(posedge clock) begin
    act_q     <= act_d;
    cmp_idx_q <= cmp_idx_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = (num_cycles != '0) ? S_RUN : S_SCAN;
      S_RUN:          if (cnt_q == n_q - CYC_W'(1)) state_d = S_SCAN;
      S_SCAN:         if (scan_idx_q == LAST_IDX) state_d = S_DRAIN;
      S_DRAIN:        state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    start_ok   = start && (state_q == S_IDLE || state_q == S_DONE);
    n_d        = start_ok ? num_cycles : n_q;
    cnt_d      = (state_q == S_RUN) ? cnt_q + CYC_W'(1) : '0;
    scan_idx_d = (state_q == S_SCAN) ? scan_idx_q + 5'd1 : '0;
    cmp_vld_d  = (state_q == S_SCAN);
    act_d      = data_readRegA;
    cmp_idx_d  = scan_idx_q;
    mismatch   = cmp_vld_q && (exp_q != act_q);
    err_d      = start_ok ? '0 : err_q + {5'd0, mismatch};
    mm_reg_d   = mismatch ? cmp_idx_q : mm_reg_q;
    mm_exp_d   = mismatch ? exp_q : mm_exp_q;
    mm_act_d   = mismatch ? act_q : mm_act_q;
  end

  always_comb begin
    busy           = (state_q == S_RUN) || (state_q == S_SCAN) || (state_q == S_DRAIN);
    done           = (state_q == S_DONE);
    pass           = done && (err_q == '0);
    error_count    = err_q;
    ctrl_readRegA  = (state_q == S_SCAN) ? scan_idx_q : cpu_rs1;
    exp_addr       = (state_q == S_SCAN) ? scan_idx_q : 5'd0;
    mismatch_valid = mismatch;
    mismatch_reg   = mismatch ? cmp_idx_q : mm_reg_q;
    mismatch_exp   = mismatch ? exp_q : mm_exp_q;
    mismatch_act   = mismatch ? act_q : mm_act_q;
  end

endmodule
